fifo_rd_stream: RTL and testbench

Read-side drain stage for the dual-clock FIFO, clocked entirely in the FIFO read domain. It pops words from the FIFO's read port (`rempty`/`rinc`/`rdata`) and presents them on a registered valid/ready stream through a 2-entry output buffer. `m_ready` has no combinational path to `rinc`. It also supports a synchronous flush and keeps a delivered-word counter.

---
 rtl/fifo_rd_stream.sv | 78 +++++++
 tb/tb_fifo_rd_stream.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-domain drain stage: pops the dual-clock FIFO into a 2-entry registered
// buffer and presents it as a valid/ready stream with flush and a delivery counter.
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CW    = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  input  logic             flush,
  output logic [1:0]       occ,
  output logic [CW-1:0]    xfer_cnt
);

  logic [DSIZE-1:0] e0_q, e0_d;
  logic [DSIZE-1:0] e1_q, e1_d;
  logic [1:0]       occ_q, occ_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pop;
  logic             acc;

  // Pop gating looks only at registered occupancy, keeping m_ready off the rinc path.
  always_comb begin
    rinc    = rrst_n & ~rempty & (occ_q != 2'd2) & ~flush;
    m_valid = (occ_q != 2'd0) & ~flush;
    pop     = rinc;
    acc     = m_valid & m_ready;
    m_data  = e0_q;
    occ     = occ_q;
    xfer_cnt = cnt_q;
  end

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    cnt_d = cnt_q;
    if (acc) cnt_d = cnt_q + 1'b1;
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      unique case ({pop, acc})
        2'b10: begin
          if (occ_q == 2'd0) e0_d = rdata;
          else               e1_d = rdata;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          occ_d = occ_q - 2'd1;
        end
        // Only reachable at occ=1: head leaves and the new word takes its place.
        2'b11: e0_d = rdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= '0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed + randomized bench for fifo_rd_stream, checked against a queue-based
// model of the FIFO and the 2-word output buffer.
module tb_fifo_rd_stream;

  logic        rclk = 1'b0;
  logic        rrst_n;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc, m_valid, m_ready, flush;
  logic [7:0]  m_data;
  logic [1:0]  occ;
  logic [15:0] xfer_cnt;
  logic        rinc4, m_valid4;
  logic [7:0]  m_data4;
  logic [1:0]  occ4;
  logic [3:0]  xfer_cnt4;

  fifo_rd_stream #(.DSIZE(8), .CW(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .flush(flush),
    .occ(occ), .xfer_cnt(xfer_cnt)
  );

  fifo_rd_stream #(.DSIZE(8), .CW(4)) dut4 (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc4),
    .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .flush(flush),
    .occ(occ4), .xfer_cnt(xfer_cnt4)
  );

  always #5 rclk = ~rclk;

  int          n_vec = 0;
  int          n_mis = 0;
  logic [7:0]  fifo_q[$];
  logic [7:0]  buf_q[$];
  logic [7:0]  pop_log[$];
  logic [7:0]  dlv_log[$];
  int          cnt = 0;
  int          dut_pops = 0;
  int          max_occ = 0;
  logic        force_empty = 1'b0;
  logic        chk_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: present FIFO head, check outputs, advance model at the edge.
  task automatic tick();
    logic er, ev, acc;
    rempty = force_empty || (fifo_q.size() == 0);
    rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
    #1;
    er = rrst_n && !rempty && (buf_q.size() < 2) && !flush;
    ev = (buf_q.size() != 0) && !flush;
    if (chk_en) begin
      chk("rinc", rinc, er);
      chk("m_valid", m_valid, ev);
      chk("occ", occ, buf_q.size());
      chk("xfer_cnt", xfer_cnt, cnt % 65536);
      chk("rinc4", rinc4, er);
      chk("m_valid4", m_valid4, ev);
      chk("occ4", occ4, buf_q.size());
      chk("xfer_cnt4", xfer_cnt4, cnt % 16);
      if (ev) begin
        chk("m_data", m_data, buf_q[0]);
        chk("m_data4", m_data4, buf_q[0]);
      end
      if (rempty) chk("rinc_while_empty", rinc, 1'b0);
    end
    if (int'(occ) > max_occ) max_occ = int'(occ);
    if (rinc && !rempty) begin dut_pops++; pop_log.push_back(rdata); end
    if (m_valid && m_ready) dlv_log.push_back(m_data);
    acc = ev && m_ready;
    @(posedge rclk);
    if (!rrst_n) begin
      buf_q.delete();
      cnt = 0;
    end else if (flush) begin
      buf_q.delete();
    end else begin
      if (acc) begin void'(buf_q.pop_front()); cnt++; end
      if (er) buf_q.push_back(fifo_q.pop_front());
    end
    @(negedge rclk);
  endtask

  initial begin
    int p0;
    rrst_n = 1'b0; m_ready = 1'b1; flush = 1'b0; rempty = 1'b0; rdata = 8'hA5;
    @(negedge rclk);
    // Reset: FIFO claims non-empty, DUT must not pop.
    fifo_q.push_back(8'hA5);
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_rinc", rinc, 1'b0);
    chk("rst_m_data", m_data, 8'h00);
    chk("rst_occ", occ, 2'd0);
    chk("rst_xfer", xfer_cnt, 16'd0);
    fifo_q.delete();
    rrst_n = 1'b1;

    // Streaming 01..10 with m_ready high.
    for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
    max_occ = 0;
    for (int i = 0; i < 19; i++) tick();
    chk("stream_occ_max", max_occ, 1);
    chk("stream_xfer", xfer_cnt, 16'd16);
    chk("stream_xfer4", xfer_cnt4, 4'd0);

    // Back-pressure.
    m_ready = 1'b0;
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
    p0 = dut_pops;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_pops", dut_pops - p0, 2);
    chk("bp_occ", occ, 2'd2);
    chk("bp_rinc", rinc, 1'b0);
    m_ready = 1'b1;
    tick();
    chk("wrap_xfer4", xfer_cnt4, 4'd1);
    tick(); tick();
    chk("bp_dlv0", dlv_log[16], 8'h11);
    chk("bp_dlv1", dlv_log[17], 8'h22);
    chk("bp_dlv2", dlv_log[18], 8'h33);
    chk("bp_xfer", xfer_cnt, 16'd19);

    // Flush with two words buffered and the sink ready.
    m_ready = 1'b0;
    fifo_q.push_back(8'h44); fifo_q.push_back(8'h55);
    for (int i = 0; i < 3; i++) tick();
    fifo_q.push_back(8'h66);
    m_ready = 1'b1; flush = 1'b1;
    p0 = dut_pops;
    tick();
    flush = 1'b0;
    chk("fl_nopop", dut_pops - p0, 0);
    chk("fl_occ", occ, 2'd0);
    chk("fl_xfer", xfer_cnt, 16'd19);
    tick();
    chk("fl_valid", m_valid, 1'b1);
    chk("fl_data", m_data, 8'h66);
    tick(); tick();

    // Toggling empty flag with random back-pressure.
    pop_log.delete(); dlv_log.delete();
    for (int i = 0; i < 300; i++) begin
      force_empty = i[0];
      m_ready = 1'($urandom);
      if (fifo_q.size() < 4 && ($urandom % 3) == 0) fifo_q.push_back(8'($urandom));
      tick();
    end
    force_empty = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 20 && (fifo_q.size() != 0 || buf_q.size() != 0); i++) tick();
    chk("rnd_drained", buf_q.size() + fifo_q.size(), 0);
    chk("rnd_len", dlv_log.size(), pop_log.size());
    for (int i = 0; i < pop_log.size() && i < dlv_log.size(); i++)
      chk("rnd_order", dlv_log[i], pop_log[i]);

    // Reset mid-stream drops buffered words.
    m_ready = 1'b0;
    fifo_q.push_back(8'h77); fifo_q.push_back(8'h88);
    tick(); tick();
    rrst_n = 1'b0;
    tick();
    rrst_n = 1'b1;
    chk("mrst_occ", occ, 2'd0);
    chk("mrst_valid", m_valid, 1'b0);
    chk("mrst_data", m_data, 8'h00);
    chk("mrst_xfer", xfer_cnt, 16'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
